// File: rtl/servo_pkg.sv
// servo_pkg: shared state type, DAC rails and saturating add for the servo output path
package servo_pkg;
  localparam int DW = 16;
  localparam logic signed [DW-1:0] DAC_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] DAC_MIN = -16'sh8000;
  typedef enum logic [1:0] {IDLE, TRACK, HOLD} out_state_t;
  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    return (s[DW] != s[DW-1]) ? (s[DW] ? DAC_MIN : DAC_MAX) : s[DW-1:0];
  endfunction
endpackage

// File: rtl/slew_limiter.sv
// slew_limiter: output register that moves toward its target by at most step per enabled cycle
module slew_limiter #(
  parameter int WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] target_in,
  input  logic [WIDTH-1:0]        step_in,
  input  logic                    enable_in,
  input  logic                    hold_in,
  output logic signed [WIDTH-1:0] value_out
);
  logic signed [WIDTH-1:0] out_q, out_d;
  logic signed [WIDTH+1:0] cur_w, step_w, delta_w, mag_w, stepped_w;
  logic limit_w;
  // two guard bits keep delta exact across the full signed range
  always_comb begin
    cur_w = {{2{out_q[WIDTH-1]}}, out_q};
    step_w = {2'b00, step_in};
    delta_w = {{2{target_in[WIDTH-1]}}, target_in} - cur_w;
    mag_w = delta_w[WIDTH+1] ? -delta_w : delta_w;
    limit_w = (step_in != '0) && (mag_w > step_w);
    stepped_w = delta_w[WIDTH+1] ? cur_w - step_w : cur_w + step_w;
    out_d = hold_in ? out_q : limit_w ? stepped_w[WIDTH-1:0] : target_in;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) out_q <= '0;
    else if (enable_in) out_q <= out_d;
  assign value_out = out_q;
endmodule

// File: rtl/servo_output_stage.sv
// servo_output_stage: saturating sum, window clamp, slew limit, bumpless hold and rail alarm ahead of the DAC
module servo_output_stage
  import servo_pkg::*;
#(
  parameter int WIDTH = DW,
  parameter int RAIL_CNT_W = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [WIDTH-1:0]      sweep_in,
  input  logic [WIDTH-1:0]      servo_in,
  input  logic                  valid_in,
  input  logic                  hold_in,
  input  logic [WIDTH-1:0]      max_in,
  input  logic [WIDTH-1:0]      min_in,
  input  logic [WIDTH-1:0]      slew_in,
  input  logic [RAIL_CNT_W-1:0] rail_limit_in,
  output logic [WIDTH-1:0]      dac_out,
  output logic                  valid_out,
  output logic                  sat_out,
  output logic                  cfg_err_out,
  output logic                  rail_alarm_out,
  output logic [RAIL_CNT_W-1:0] rail_count_out
);
  out_state_t state_q, state_d;
  logic signed [WIDTH:0] sum_w;
  logic signed [WIDTH-1:0] mx_w, mn_w, sa_w, clamp_w, dac_w, target_w, tgt_q;
  logic cfg_w, sat_w, hold_w;
  logic v1_q, sat1_q, cfg1_q;
  logic [WIDTH-1:0] slew1_q;
  logic [RAIL_CNT_W-1:0] lim1_q, cnt_q, cnt_d;
  logic valid_q, sat_q, cfg_q, alarm_q;
  always_comb begin
    mx_w = $signed(max_in);
    mn_w = $signed(min_in);
    sum_w = $signed({sweep_in[WIDTH-1], sweep_in}) + $signed({servo_in[WIDTH-1], servo_in});
    sa_w = sat_add($signed(sweep_in), $signed(servo_in));
    clamp_w = (sa_w > mx_w) ? mx_w : (sa_w < mn_w) ? mn_w : sa_w;
    cfg_w = mn_w > mx_w;
    sat_w = cfg_w || ({clamp_w[WIDTH-1], clamp_w} != sum_w);
    state_d = hold_in ? HOLD : TRACK;
    hold_w = state_q == HOLD;
    // an inverted window resolves to the live output, so the sample cannot move it
    target_w = cfg1_q ? dac_w : tgt_q;
    cnt_d = hold_w ? cnt_q : !sat1_q ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end
  // stage 1 and the state register advance together on each accepted sample
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      v1_q <= 1'b0;
      tgt_q <= '0;
      sat1_q <= 1'b0;
      cfg1_q <= 1'b0;
      slew1_q <= '0;
      lim1_q <= '0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        state_q <= state_d;
        tgt_q <= clamp_w;
        sat1_q <= sat_w;
        cfg1_q <= cfg_w;
        slew1_q <= slew_in;
        lim1_q <= rail_limit_in;
      end
    end
  slew_limiter #(.WIDTH(WIDTH)) u_slew (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .target_in(target_w),
    .step_in(slew1_q),
    .enable_in(v1_q),
    .hold_in(hold_w),
    .value_out(dac_w)
  );
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      valid_q <= 1'b0;
      sat_q <= 1'b0;
      cfg_q <= 1'b0;
      cnt_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        sat_q <= sat1_q;
        cfg_q <= cfg1_q;
        cnt_q <= cnt_d;
        alarm_q <= (lim1_q != '0) && (cnt_d >= lim1_q);
      end
    end
  assign dac_out = dac_w;
  assign valid_out = valid_q;
  assign sat_out = sat_q;
  assign cfg_err_out = cfg_q;
  assign rail_alarm_out = alarm_q;
  assign rail_count_out = cnt_q;
endmodule

// File: tb/tb_servo_output_stage.sv
// tb_servo_output_stage: scoreboard bench with an arithmetic reference model of the output stage
module tb_servo_output_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sweep_in = '0, servo_in = '0, max_in = 16'h7FFF, min_in = 16'h8000, slew_in = '0;
  logic valid_in = 1'b0, hold_in = 1'b0;
  logic [23:0] rail_limit_in = '0;
  logic [15:0] dac_out;
  logic valid_out, sat_out, cfg_err_out, rail_alarm_out;
  logic [23:0] rail_count_out;
  typedef struct {int dac; bit sat; bit cfg; int cnt; bit alarm;} exp_t;
  exp_t q[$];
  exp_t me;
  int errors = 0, checks = 0;
  int mdac = 0, mcnt = 0;

  servo_output_stage dut (
    .clk_in(clk), .rst_in(rst), .sweep_in(sweep_in), .servo_in(servo_in),
    .valid_in(valid_in), .hold_in(hold_in), .max_in(max_in), .min_in(min_in),
    .slew_in(slew_in), .rail_limit_in(rail_limit_in), .dac_out(dac_out),
    .valid_out(valid_out), .sat_out(sat_out), .cfg_err_out(cfg_err_out),
    .rail_alarm_out(rail_alarm_out), .rail_count_out(rail_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: each sample is evaluated from the arithmetic rules, in order
  task automatic send(input logic [15:0] sw, input logic [15:0] sv, input bit h);
    int sum, mx, mn, sl, lim, tgt, d;
    bit s, c;
    sweep_in = sw; servo_in = sv; hold_in = h; valid_in = 1'b1;
    sum = int'($signed(sw)) + int'($signed(sv));
    mx = int'($signed(max_in)); mn = int'($signed(min_in));
    sl = int'(slew_in); lim = int'(rail_limit_in);
    c = mn > mx;
    if (c) begin tgt = mdac; s = 1'b1; end
    else begin
      tgt = (sum > mx) ? mx : (sum < mn) ? mn : sum;
      s = tgt != sum;
    end
    if (!h) begin
      d = tgt - mdac;
      if (sl != 0 && (d > sl || -d > sl)) mdac += (d > 0) ? sl : -sl;
      else mdac = tgt;
      mcnt = !s ? 0 : (mcnt == 24'hFFFFFF) ? mcnt : mcnt + 1;
    end
    q.push_back('{mdac, s, c, mcnt, (lim != 0) && (mcnt >= lim)});
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", q.size(), 0);
  endtask

  always @(negedge clk)
    if (!rst && valid_out) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_valid: got valid_out=1 expected no output");
      end else begin
        me = q.pop_front();
        check("dac", 32'($signed(dac_out)), me.dac);
        check("sat", sat_out, me.sat);
        check("cfg_err", cfg_err_out, me.cfg);
        check("rail_count", rail_count_out, me.cnt);
        check("rail_alarm", rail_alarm_out, me.alarm);
      end
    end

  initial begin
    #1;
    check("rst_dac", dac_out, 0);
    check("rst_valid", valid_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("idle_valid", valid_out, 0);
    // sum saturation
    send(16'h6000, 16'h3000, 0); drain();
    check("sum_sat_dac", dac_out, 16'h7FFF);
    check("sum_sat_flag", sat_out, 1);
    // window clamp
    max_in = 16'h1800; min_in = 16'hE000;
    send(16'h1000, 16'h1000, 0); drain();
    check("clamp_dac", dac_out, 16'h1800);
    check("clamp_flag", sat_out, 1);
    // slew ramp from zero
    max_in = 16'h7FFF; min_in = 16'h8000;
    send(16'h0000, 16'h0000, 0);
    slew_in = 16'h0100;
    for (int i = 0; i < 5; i++) send(16'h0400, 16'h0050, 0);
    drain();
    check("slew_final", dac_out, 16'h0450);
    slew_in = 16'h0000;
    send(16'h2000, 16'h0000, 0); drain();
    check("slew_unlimited", dac_out, 16'h2000);
    // bumpless hold
    send(16'h0200, 16'h0000, 0);
    for (int i = 0; i < 4; i++) send(16'h7000, 16'h0000, 1);
    drain();
    check("hold_dac", dac_out, 16'h0200);
    slew_in = 16'h0400;
    send(16'h7000, 16'h0000, 0); drain();
    check("release_1", dac_out, 16'h0600);
    send(16'h7000, 16'h0000, 0); drain();
    check("release_2", dac_out, 16'h0A00);
    // rail alarm
    slew_in = 16'h0000; rail_limit_in = 24'd5;
    send(16'h0000, 16'h0000, 0);
    for (int i = 0; i < 4; i++) send(16'h7000, 16'h7000, 0);
    drain();
    check("rail_before", rail_alarm_out, 0);
    send(16'h7000, 16'h7000, 0); drain();
    check("rail_fifth", rail_alarm_out, 1);
    check("rail_count5", rail_count_out, 5);
    send(16'h0010, 16'h0000, 0); drain();
    check("rail_clear", rail_alarm_out, 0);
    check("rail_count0", rail_count_out, 0);
    rail_limit_in = 24'd0;
    for (int i = 0; i < 8; i++) send(16'h9000, 16'h9000, 0);
    drain();
    check("rail_disabled", rail_alarm_out, 0);
    check("rail_count8", rail_count_out, 8);
    // inverted window keeps the output
    send(16'h0300, 16'h0000, 0);
    min_in = 16'h1000; max_in = 16'h0800;
    send(16'h0100, 16'h0000, 0); drain();
    check("cfg_dac", dac_out, 16'h0300);
    check("cfg_flag", cfg_err_out, 1);
    check("cfg_sat", sat_out, 1);
    // reset mid-ramp
    min_in = 16'h8000; max_in = 16'h7FFF; slew_in = 16'h0010;
    for (int i = 0; i < 6; i++) send(16'h7000, 16'h0000, 0);
    valid_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    valid_in = 1'b0;
    q.delete(); mdac = 0; mcnt = 0;
    check("midrst_dac", dac_out, 0);
    check("midrst_valid", valid_out, 0);
    check("midrst_count", rail_count_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a, b;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin min_in = a; max_in = b; end
      else if ($signed(a) > $signed(b)) begin min_in = b; max_in = a; end
      else begin min_in = a; max_in = b; end
      slew_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000));
      rail_limit_in = 24'($urandom_range(0, 6));
      send(16'($urandom), 16'($urandom), $urandom_range(0, 4) == 0);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
